// File: rtl/rv32_pkg.sv
// Shared RV32I definitions used by the memory stage: funct3 load/store
// encodings and the bus access FSM states.
package rv32_pkg;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic {
        IDLE,
        BUSY
    } mem_state_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the data bus: byte enables, store replication,
// misalignment detection and load lane extraction with extension.
module mem_align
    import rv32_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic        misaligned,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    assign shifted = load_word >> {addr_lo, 3'b000};

    always_comb begin
        byte_en    = 4'b1111;
        store_word = store_data;
        misaligned = 1'b0;
        case (op)
            MEM_B, MEM_BU: begin
                byte_en    = 4'b0001 << addr_lo;
                store_word = {4{store_data[7:0]}};
            end
            MEM_H, MEM_HU: begin
                byte_en    = 4'b0011 << addr_lo;
                store_word = {2{store_data[15:0]}};
                misaligned = addr_lo[0];
            end
            default: misaligned = |addr_lo;
        endcase
    end

    // Word loads are always aligned here, so the unshifted word is correct.
    always_comb begin
        load_data = shifted;
        case (op)
            MEM_B:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            MEM_BU:  load_data = {24'h0, shifted[7:0]};
            MEM_H:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            MEM_HU:  load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: req/ack data bus master with timeout, and the
// MEM pipeline register feeding writeback.
module mem_stage
    import rv32_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        EX_Mem_wr_en,
    input  logic        EX_Mem_rd_en,
    input  logic [2:0]  EX_Mem_op,
    input  logic [31:0] EX_Rs2_data,
    input  logic [31:0] EX_ALU_result,
    input  logic        EX_MemToReg,
    input  logic        EX_RegFile_wr_en,
    input  logic [4:0]  EX_Rd_addr,
    output logic        MEM_Stall,
    output logic        MEM_RegFile_wr_en,
    output logic [4:0]  MEM_Rd_addr,
    output logic [31:0] MEM_Rd_data,
    output logic        MEM_Misaligned,
    output logic        MEM_Bus_error,
    output logic        DMem_req,
    output logic        DMem_we,
    output logic [31:0] DMem_addr,
    output logic [3:0]  DMem_be,
    output logic [31:0] DMem_wdata,
    input  logic        DMem_ack,
    input  logic [31:0] DMem_rdata
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] COUNT_MAX = CW'(TIMEOUT);

    mem_state_t  state, state_nxt;
    logic [CW-1:0] count;

    logic [2:0]  cap_op;
    logic [31:0] cap_addr;
    logic [4:0]  cap_rd;
    logic        cap_mem_to_reg;
    logic        cap_rf_wr_en;
    logic        cap_store;

    logic        access;
    logic        misaligned;
    logic [3:0]  byte_en;
    logic [31:0] store_word;
    logic [31:0] load_data;
    logic [2:0]  align_op;
    logic [1:0]  align_addr;
    logic        start_access;
    logic        bus_done;
    logic        bus_timeout;

    assign access = EX_Mem_rd_en | EX_Mem_wr_en;

    // While BUSY the lane logic serves the captured load; in IDLE it checks EX.
    assign align_op   = (state == BUSY) ? cap_op : EX_Mem_op;
    assign align_addr = (state == BUSY) ? cap_addr[1:0] : EX_ALU_result[1:0];

    mem_align u_align (
        .op         (align_op),
        .addr_lo    (align_addr),
        .store_data (EX_Rs2_data),
        .load_word  (DMem_rdata),
        .byte_en    (byte_en),
        .store_word (store_word),
        .misaligned (misaligned),
        .load_data  (load_data)
    );

    always_comb begin
        state_nxt    = state;
        start_access = 1'b0;
        bus_done     = 1'b0;
        bus_timeout  = 1'b0;
        MEM_Stall    = 1'b0;
        case (state)
            IDLE: begin
                if (access && !misaligned) begin
                    start_access = 1'b1;
                    MEM_Stall    = 1'b1;
                    state_nxt    = BUSY;
                end
            end
            BUSY: begin
                if (DMem_ack) begin
                    bus_done  = 1'b1;
                    state_nxt = IDLE;
                end else if (count == COUNT_MAX) begin
                    bus_timeout = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    MEM_Stall = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // MEM register defaults to a bubble; only retiring instructions overwrite it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count             <= '0;
            cap_op            <= '0;
            cap_addr          <= '0;
            cap_rd            <= '0;
            cap_mem_to_reg    <= 1'b0;
            cap_rf_wr_en      <= 1'b0;
            cap_store         <= 1'b0;
            MEM_RegFile_wr_en <= 1'b0;
            MEM_Rd_addr       <= '0;
            MEM_Rd_data       <= '0;
            MEM_Misaligned    <= 1'b0;
            MEM_Bus_error     <= 1'b0;
            DMem_req          <= 1'b0;
            DMem_we           <= 1'b0;
            DMem_addr         <= '0;
            DMem_be           <= '0;
            DMem_wdata        <= '0;
        end else begin
            MEM_RegFile_wr_en <= 1'b0;
            MEM_Rd_addr       <= '0;
            MEM_Rd_data       <= '0;
            MEM_Misaligned    <= 1'b0;
            MEM_Bus_error     <= 1'b0;
            if (start_access) begin
                DMem_req       <= 1'b1;
                DMem_we        <= EX_Mem_wr_en;
                DMem_addr      <= {EX_ALU_result[31:2], 2'b00};
                DMem_be        <= byte_en;
                DMem_wdata     <= store_word;
                cap_op         <= EX_Mem_op;
                cap_addr       <= EX_ALU_result;
                cap_rd         <= EX_Rd_addr;
                cap_mem_to_reg <= EX_MemToReg;
                cap_rf_wr_en   <= EX_RegFile_wr_en;
                cap_store      <= EX_Mem_wr_en;
                count          <= '0;
            end else if (state == IDLE) begin
                if (access) begin
                    MEM_Misaligned <= 1'b1;
                end else begin
                    MEM_RegFile_wr_en <= EX_RegFile_wr_en;
                    MEM_Rd_addr       <= EX_Rd_addr;
                    MEM_Rd_data       <= EX_ALU_result;
                end
            end else if (bus_done) begin
                DMem_req          <= 1'b0;
                MEM_RegFile_wr_en <= cap_rf_wr_en & ~cap_store;
                MEM_Rd_addr       <= cap_rd;
                MEM_Rd_data       <= cap_mem_to_reg ? load_data : cap_addr;
            end else if (bus_timeout) begin
                DMem_req      <= 1'b0;
                MEM_Bus_error <= 1'b1;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a byte-addressed reference memory predicts
// writeback results and bus requests; a bus responder and a monitor check them.
module tb_mem_stage;
    import rv32_pkg::*;

    localparam int TO = 4;

    logic        Clk;
    logic        Reset;
    logic        EX_Mem_wr_en;
    logic        EX_Mem_rd_en;
    logic [2:0]  EX_Mem_op;
    logic [31:0] EX_Rs2_data;
    logic [31:0] EX_ALU_result;
    logic        EX_MemToReg;
    logic        EX_RegFile_wr_en;
    logic [4:0]  EX_Rd_addr;
    logic        MEM_Stall;
    logic        MEM_RegFile_wr_en;
    logic [4:0]  MEM_Rd_addr;
    logic [31:0] MEM_Rd_data;
    logic        MEM_Misaligned;
    logic        MEM_Bus_error;
    logic        DMem_req;
    logic        DMem_we;
    logic [31:0] DMem_addr;
    logic [3:0]  DMem_be;
    logic [31:0] DMem_wdata;
    logic        DMem_ack;
    logic [31:0] DMem_rdata;

    mem_stage #(.TIMEOUT(TO)) dut (
        .Clk(Clk), .Reset(Reset),
        .EX_Mem_wr_en(EX_Mem_wr_en), .EX_Mem_rd_en(EX_Mem_rd_en), .EX_Mem_op(EX_Mem_op),
        .EX_Rs2_data(EX_Rs2_data), .EX_ALU_result(EX_ALU_result), .EX_MemToReg(EX_MemToReg),
        .EX_RegFile_wr_en(EX_RegFile_wr_en), .EX_Rd_addr(EX_Rd_addr),
        .MEM_Stall(MEM_Stall), .MEM_RegFile_wr_en(MEM_RegFile_wr_en), .MEM_Rd_addr(MEM_Rd_addr),
        .MEM_Rd_data(MEM_Rd_data), .MEM_Misaligned(MEM_Misaligned), .MEM_Bus_error(MEM_Bus_error),
        .DMem_req(DMem_req), .DMem_we(DMem_we), .DMem_addr(DMem_addr), .DMem_be(DMem_be),
        .DMem_wdata(DMem_wdata), .DMem_ack(DMem_ack), .DMem_rdata(DMem_rdata)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        wr;
        logic        mis;
        logic        berr;
        logic        chk;
        logic [4:0]  rd;
        logic [31:0] data;
    } res_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          delay;
    } bus_t;

    res_t res_q[$];
    bus_t bus_q[$];
    logic [7:0] ref_bytes [logic [31:0]];
    logic [7:0] bus_bytes [logic [31:0]];

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    bit   ex_valid = 1'b0;
    bit   retire   = 1'b0;
    bit   manual   = 1'b0;
    logic man_ack  = 1'b0;
    logic [31:0] man_rdata = '0;

    function automatic void checkOutput(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] defByte(logic [31:0] a);
        return 8'((a * 37) ^ 32'h5B);
    endfunction

    function automatic logic [7:0] refRead(logic [31:0] a);
        return ref_bytes.exists(a) ? ref_bytes[a] : defByte(a);
    endfunction

    function automatic logic [31:0] busWord(logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++)
            w[8*i +: 8] = bus_bytes.exists(a + 32'(i)) ? bus_bytes[a + 32'(i)] : defByte(a + 32'(i));
        return w;
    endfunction

    function automatic void presetWord(logic [31:0] a, logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            ref_bytes[a + 32'(i)] = w[8*i +: 8];
            bus_bytes[a + 32'(i)] = w[8*i +: 8];
        end
    endfunction

    // kind: 0 non-memory, 1 load, 2 store, 3 load+store (store wins).
    // delay: ack in the (delay+1)th request cycle; beyond TO means no ack.
    task automatic applyStimulus(input int kind, input logic [2:0] op, input logic [31:0] addr,
                                 input logic [31:0] rs2, input logic m2r, input logic rfwe,
                                 input logic [4:0] rd, input int delay,
                                 input bit use_lit, input logic [31:0] lit);
        res_t   r;
        bus_t   b;
        int     size;
        int     lat;
        int     cyc;
        longint val;
        bit     store;
        store = (kind >= 2);
        size  = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
        r = '{wr: 1'b0, mis: 1'b0, berr: 1'b0, chk: 1'b0, rd: '0, data: '0};
        if (kind == 0) begin
            r.wr = rfwe; r.rd = rd; r.data = addr; r.chk = 1'b1;
            lat = 1;
        end else if (addr % size != 0) begin
            r.mis = 1'b1;
            lat = 1;
        end else begin
            b.we    = store;
            b.addr  = addr - (addr % 4);
            b.be    = 4'(((1 << size) - 1) << (addr % 4));
            b.wdata = (size == 1) ? {4{rs2[7:0]}} : (size == 2) ? {2{rs2[15:0]}} : rs2;
            b.delay = delay;
            bus_q.push_back(b);
            if (delay > TO) begin
                r.berr = 1'b1;
                lat = TO + 2;
            end else begin
                lat = delay + 2;
                if (store) begin
                    for (int i = 0; i < size; i++) ref_bytes[addr + 32'(i)] = rs2[8*i +: 8];
                end else begin
                    val = 0;
                    for (int i = 0; i < size; i++)
                        val = val + (longint'(refRead(addr + 32'(i))) << (8 * i));
                    if (!op[2] && val[8*size-1]) val = val - (longint'(1) << (8 * size));
                    r.wr = rfwe; r.rd = rd; r.chk = rfwe;
                    r.data = m2r ? 32'(val) : addr;
                    if (use_lit) r.data = lit;
                end
            end
        end
        res_q.push_back(r);
        @(posedge Clk);
        #1;
        EX_Mem_rd_en     = (kind == 1) || (kind == 3);
        EX_Mem_wr_en     = (kind >= 2);
        EX_Mem_op        = op;
        EX_ALU_result    = addr;
        EX_Rs2_data      = rs2;
        EX_MemToReg      = m2r;
        EX_RegFile_wr_en = rfwe;
        EX_Rd_addr       = rd;
        ex_valid         = 1'b1;
        cyc = 0;
        do begin
            @(negedge Clk);
            cyc++;
        end while (MEM_Stall && cyc < 40);
        checkOutput("latency", 64'(cyc), 64'(lat));
    endtask

    task automatic idleInputs();
        EX_Mem_rd_en = 0; EX_Mem_wr_en = 0; EX_Mem_op = '0; EX_ALU_result = '0;
        EX_Rs2_data = '0; EX_MemToReg = 0; EX_RegFile_wr_en = 0; EX_Rd_addr = '0;
        ex_valid = 1'b0;
    endtask

    // Writeback monitor: a retirement is an EX instruction seen with stall low.
    always @(negedge Clk) begin
        res_t r;
        if (mon_en) begin
            if (retire) begin
                if (res_q.size() == 0) begin
                    checkOutput("retire_without_expect", 64'(1), 64'(0));
                end else begin
                    r = res_q.pop_front();
                    checkOutput("wb_wr_en", 64'(MEM_RegFile_wr_en), 64'(r.wr));
                    checkOutput("wb_misaligned", 64'(MEM_Misaligned), 64'(r.mis));
                    checkOutput("wb_bus_error", 64'(MEM_Bus_error), 64'(r.berr));
                    if (r.chk) begin
                        checkOutput("wb_rd", 64'(MEM_Rd_addr), 64'(r.rd));
                        checkOutput("wb_data", 64'(MEM_Rd_data), 64'(r.data));
                    end
                end
            end else begin
                checkOutput("wb_bubble", {24'h0, MEM_RegFile_wr_en, MEM_Misaligned, MEM_Bus_error,
                                          MEM_Rd_addr, MEM_Rd_data}, 64'(0));
            end
            retire = ex_valid && !MEM_Stall;
        end
    end

    // Bus responder: checks each request against the prediction and acks on schedule.
    bit   rsp_active = 1'b0;
    int   rsp_seen   = 0;
    bus_t rsp_b;
    always @(posedge Clk) begin
        #2;
        if (manual) begin
            DMem_ack   = man_ack;
            DMem_rdata = man_rdata;
        end else if (DMem_req) begin
            if (!rsp_active) begin
                rsp_active = 1'b1;
                rsp_seen   = 0;
                if (bus_q.size() == 0) begin
                    checkOutput("spurious_req", 64'(1), 64'(0));
                    rsp_b = '{we: 1'b0, addr: '0, be: '0, wdata: '0, delay: 999};
                end else begin
                    rsp_b = bus_q.pop_front();
                end
            end
            checkOutput("bus_addr", 64'(DMem_addr), 64'(rsp_b.addr));
            checkOutput("bus_we", 64'(DMem_we), 64'(rsp_b.we));
            checkOutput("bus_be", 64'(DMem_be), 64'(rsp_b.be));
            if (rsp_b.we) checkOutput("bus_wdata", 64'(DMem_wdata), 64'(rsp_b.wdata));
            if (rsp_seen == rsp_b.delay) begin
                DMem_ack = 1'b1;
                if (DMem_we)
                    for (int i = 0; i < 4; i++)
                        if (DMem_be[i]) bus_bytes[DMem_addr + 32'(i)] = DMem_wdata[8*i +: 8];
                DMem_rdata = busWord(DMem_addr);
            end else begin
                DMem_ack   = 1'b0;
                DMem_rdata = $urandom;
            end
            rsp_seen++;
        end else begin
            if (rsp_active) begin
                rsp_active = 1'b0;
                checkOutput("req_cycles", 64'(rsp_seen),
                            64'((rsp_b.delay <= TO) ? rsp_b.delay + 1 : TO + 1));
            end
            DMem_ack   = ($urandom_range(0, 3) == 0);
            DMem_rdata = $urandom;
        end
    end

    initial begin
        logic [2:0] load_ops [5];
        int         kind;
        logic [2:0] op;
        load_ops = '{MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU};
        DMem_ack = 1'b0;
        DMem_rdata = '0;
        Reset = 1'b1;
        idleInputs();
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        checkOutput("reset_mem_regs", {24'h0, MEM_RegFile_wr_en, MEM_Misaligned, MEM_Bus_error,
                                       MEM_Rd_addr, MEM_Rd_data}, 64'(0));
        checkOutput("reset_bus", {DMem_req, DMem_we, DMem_be, DMem_addr}, 64'(0));
        checkOutput("reset_wdata", 64'(DMem_wdata), 64'(0));
        checkOutput("reset_stall", 64'(MEM_Stall), 64'(0));
        mon_en = 1'b1;

        // Directed cases
        applyStimulus(2, MEM_B, 32'h1003, 32'hAABBCCDD, 1'b0, 1'b1, 5'd7, 1, 0, '0);
        applyStimulus(2, MEM_H, 32'h1002, 32'h00001234, 1'b0, 1'b1, 5'd8, 0, 0, '0);
        presetWord(32'h2000, 32'h000080FF);
        applyStimulus(1, MEM_B,  32'h2001, '0, 1'b1, 1'b1, 5'd5, 1, 1, 32'hFFFFFF80);
        applyStimulus(1, MEM_BU, 32'h2001, '0, 1'b1, 1'b1, 5'd6, 0, 1, 32'h00000080);
        presetWord(32'h2000, 32'h80010000);
        applyStimulus(1, MEM_H,  32'h2002, '0, 1'b1, 1'b1, 5'd4, 2, 1, 32'hFFFF8001);
        applyStimulus(1, MEM_W,  32'h3002, '0, 1'b1, 1'b1, 5'd3, 0, 0, '0);
        applyStimulus(1, MEM_W,  32'h1000, '0, 1'b1, 1'b1, 5'd9, 3, 0, '0);
        applyStimulus(0, 3'b000, 32'h42,   '0, 1'b0, 1'b1, 5'd10, 0, 0, '0);
        applyStimulus(1, MEM_W,  32'h1004, '0, 1'b1, 1'b1, 5'd11, TO + 1, 0, '0);
        applyStimulus(1, MEM_HU, 32'h1002, '0, 1'b1, 1'b1, 5'd12, TO, 0, '0);
        applyStimulus(3, MEM_W,  32'h1008, 32'hCAFEF00D, 1'b1, 1'b1, 5'd13, 0, 0, '0);
        applyStimulus(1, MEM_W,  32'h1008, '0, 1'b1, 1'b1, 5'd14, 1, 0, '0);

        // Randomized traffic in a small window so stores and loads overlap
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                applyStimulus(0, 3'($urandom), $urandom, $urandom, 1'b0, 1'($urandom),
                              5'($urandom), 0, 0, '0);
            end else begin
                op = (kind == 1) ? load_ops[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
                applyStimulus(kind, op, 32'h4000 + 32'($urandom_range(0, 31)), $urandom,
                              ($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom),
                              $urandom_range(0, TO + 2), 0, '0);
            end
        end

        @(posedge Clk);
        #1 idleInputs();
        repeat (3) @(negedge Clk);
        checkOutput("drain_results", 64'(res_q.size()), 64'(0));
        checkOutput("drain_bus", 64'(bus_q.size()), 64'(0));

        // Reset in the second BUSY cycle, with an ack arriving just after it
        mon_en = 1'b0;
        manual = 1'b1;
        man_ack = 1'b0;
        @(posedge Clk);
        #1;
        EX_Mem_rd_en = 1'b1; EX_Mem_op = MEM_W; EX_ALU_result = 32'h2000;
        EX_MemToReg = 1'b1; EX_RegFile_wr_en = 1'b1; EX_Rd_addr = 5'd3;
        @(posedge Clk);
        @(posedge Clk);
        #1 Reset = 1'b1;
        @(negedge Clk);
        checkOutput("rst_busy_req", 64'(DMem_req), 64'(1));
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        idleInputs();
        man_ack = 1'b1;
        man_rdata = 32'h12345678;
        @(negedge Clk);
        checkOutput("rst_mem_regs", {24'h0, MEM_RegFile_wr_en, MEM_Misaligned, MEM_Bus_error,
                                     MEM_Rd_addr, MEM_Rd_data}, 64'(0));
        checkOutput("rst_bus", {DMem_req, DMem_we, DMem_be, DMem_addr}, 64'(0));
        checkOutput("rst_stall", 64'(MEM_Stall), 64'(0));
        @(posedge Clk);
        #1 man_ack = 1'b0;
        @(negedge Clk);
        checkOutput("late_ack_wb", {31'h0, MEM_RegFile_wr_en, MEM_Rd_data}, 64'(0));
        checkOutput("late_ack_req", {DMem_req, MEM_Bus_error, MEM_Stall}, 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
